// File: rtl/path_cmd_sequencer.sv
// Buffers a planned list of turn commands and hands one to the motor controller per node reached.
// Optional node watchdog enabled by defining NODE_TIMEOUT_EN.
module path_cmd_sequencer #(
  parameter int DEPTH          = 37,
  parameter int IDX_W          = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             plan_start,
  input  logic [1:0]       start_heading,
  input  logic             plan_wr,
  input  logic [1:0]       plan_cmd,
  input  logic             plan_last,
  output logic             plan_ready,
  input  logic             node_detect,
  output logic [1:0]       turn_cmd,
  output logic             turn_valid,
  input  logic             turn_ack,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       heading,
  output logic [IDX_W-1:0] cmd_index,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_NODE, ISSUE} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  state_t           state;
  logic [1:0]       buffer [DEPTH];
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] index;
  logic             wr_ok;
  logic             buf_we;

  // Headings: 00 W, 01 E, 10 N, 11 S; commands: 00 straight, 01 left, 10 right, 11 back.
  function automatic logic [1:0] turn_heading(input logic [1:0] h, input logic [1:0] c);
    logic [1:0] r;
    r = h;
    case (c)
      2'b11: r = {h[1], ~h[0]};
      2'b01: begin
        case (h)
          2'b10:   r = 2'b00;
          2'b00:   r = 2'b11;
          2'b11:   r = 2'b01;
          default: r = 2'b10;
        endcase
      end
      2'b10: begin
        case (h)
          2'b10:   r = 2'b01;
          2'b01:   r = 2'b11;
          2'b11:   r = 2'b00;
          default: r = 2'b10;
        endcase
      end
      default: r = h;
    endcase
    return r;
  endfunction

  assign wr_ok      = (count < DEPTH_IDX);
  assign plan_ready = (state == LOAD) && wr_ok;
  assign busy       = (state != IDLE);
  assign cmd_index  = index;
  assign buf_we     = (state == LOAD) && !abort && !plan_start && plan_wr && wr_ok;

  always_ff @(posedge clk_50) begin
    if (buf_we) buffer[count[AW-1:0]] <= plan_cmd;
  end

`ifdef NODE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;
  logic            wd_expired;

  // Counts cycles spent in WAIT_NODE; any other state parks it at zero so each entry starts fresh.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) wd_count <= '0;
    else if (state == WAIT_NODE) wd_count <= wd_count + WD_W'(1);
    else wd_count <= '0;
  end

  assign wd_expired = (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      error      <= 1'b0;
      heading    <= 2'b00;
      turn_cmd   <= 2'b00;
      turn_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        turn_valid <= 1'b0;
        count      <= '0;
        index      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (plan_start) begin
              state   <= LOAD;
              count   <= '0;
              index   <= '0;
              error   <= 1'b0;
              heading <= start_heading;
            end
          end
          LOAD: begin
            if (plan_start) begin
              count   <= '0;
              index   <= '0;
              error   <= 1'b0;
              heading <= start_heading;
            end else if (plan_wr) begin
              if (wr_ok) count <= count + IDX_W'(1);
              else error <= 1'b1;
              // An overflowed plan is discarded rather than partially executed.
              if (plan_last) state <= (error || !wr_ok) ? IDLE : WAIT_NODE;
            end
          end
          WAIT_NODE: begin
            if (node_detect) begin
              state      <= ISSUE;
              turn_cmd   <= buffer[index[AW-1:0]];
              turn_valid <= 1'b1;
            end
`ifdef NODE_TIMEOUT_EN
            else if (wd_expired) begin
              state <= IDLE;
              error <= 1'b1;
              count <= '0;
              index <= '0;
            end
`endif
          end
          ISSUE: begin
            if (turn_ack) begin
              turn_valid <= 1'b0;
              heading    <= turn_heading(heading, turn_cmd);
              index      <= index + IDX_W'(1);
              if (index + IDX_W'(1) == count) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= WAIT_NODE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
